// File: rtl/hold_tick_counter.sv
// Tick counter used by both the HOLD and PULSE windows. It raises o_done on the
// tick that completes HOLD_TICKS counted ticks. The clear input has priority.
module hold_tick_counter #(
  parameter int unsigned HOLD_TICKS = 6,
  parameter int unsigned CNT_W      = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic i_tick_en,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_TICKS - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (i_tick_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = i_tick_en && (r_cnt == LAST);

endmodule

// File: rtl/level_hold_driver.sv
// Output conditioner. It holds every level on o_data_out for at least HOLD_TICKS
// ticks and emits inverted pulses on request, with a one-deep request queue.
module level_hold_driver #(
  parameter int unsigned HOLD_TICKS = 6,
  parameter logic        INIT_VALUE = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick_en,
  input  logic i_data_in,
  input  logic i_pulse_req,
  output logic o_data_out,
  output logic o_busy,
  output logic o_pending,
  output logic o_req_drop
);

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2
  } state_t;

  state_t state;
  logic   r_base;
  logic   r_pend;
  logic   done;
  logic   clear;

  // The counter is held at zero in IDLE. It is also restarted on the PULSE
  // terminal tick, so the restored base level gets a full hold window.
  assign clear = (state == IDLE) || ((state == PULSE) && done);

  hold_tick_counter #(
    .HOLD_TICKS (HOLD_TICKS),
    .CNT_W      (CNT_W)
  ) u_hold_tick_counter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .clear     (clear),
    .i_tick_en (i_tick_en),
    .o_done    (done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= HOLD;
      o_data_out <= INIT_VALUE;
      r_base     <= INIT_VALUE;
      r_pend     <= 1'b0;
      o_req_drop <= 1'b0;
    end else begin
      o_req_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (i_pulse_req || r_pend) begin
            o_data_out <= ~r_base;
            r_pend     <= 1'b0;
            state      <= PULSE;
          end else if (i_data_in != r_base) begin
            o_data_out <= i_data_in;
            r_base     <= i_data_in;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (done) state <= IDLE;
        end
        PULSE: begin
          if (done) begin
            o_data_out <= r_base;
            state      <= HOLD;
          end
        end
        default: state <= HOLD;
      endcase

      // A request that arrives outside IDLE is queued. A second request while
      // one is already queued is dropped.
      if ((state != IDLE) && i_pulse_req) begin
        if (r_pend) o_req_drop <= 1'b1;
        else        r_pend     <= 1'b1;
      end
    end
  end

  assign o_busy    = (state != IDLE);
  assign o_pending = r_pend || (i_data_in != o_data_out);

endmodule

// File: tb/tb_level_hold_driver.sv
// Directed bench for level_hold_driver. A window-countdown model is compared
// against the DUT every cycle. Literal expectations pin down each scenario.
module tb_level_hold_driver;

  localparam int unsigned H = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic tick_en;
  logic data_in;
  logic pulse_req;
  logic data_out;
  logic busy;
  logic pending;
  logic req_drop;

  int n_checks = 0;
  int n_fail   = 0;

  level_hold_driver #(
    .HOLD_TICKS (H),
    .INIT_VALUE (1'b1),
    .CNT_W      (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tick_en   (tick_en),
    .i_data_in   (data_in),
    .i_pulse_req (pulse_req),
    .o_data_out  (data_out),
    .o_busy      (busy),
    .o_pending   (pending),
    .o_req_drop  (req_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the output is either idle or inside a window that has m_rem ticks left.
  // A pulse window is followed by a hold window at the base level.
  logic m_out, m_base, m_pend, m_drop, m_idle, m_in_pulse;
  int   m_rem;

  always @(posedge clk or negedge rst_n) begin : model
    logic o, b, p, d, idl, pl;
    int   r;
    if (!rst_n) begin
      m_out <= 1'b1; m_base <= 1'b1; m_pend <= 1'b0; m_drop <= 1'b0;
      m_idle <= 1'b0; m_in_pulse <= 1'b0; m_rem <= H;
    end else begin
      o = m_out; b = m_base; p = m_pend; d = 1'b0; idl = m_idle; pl = m_in_pulse; r = m_rem;
      if (m_idle) begin
        if (pulse_req || m_pend) begin
          o = !b; p = 1'b0; idl = 1'b0; pl = 1'b1; r = H;
        end else if (data_in != b) begin
          b = data_in; o = data_in; idl = 1'b0; pl = 1'b0; r = H;
        end
      end else begin
        if (pulse_req) begin
          if (p) d = 1'b1;
          else   p = 1'b1;
        end
        if (tick_en) begin
          r = r - 1;
          if (r == 0) begin
            if (pl) begin
              pl = 1'b0; o = b; r = H;
            end else begin
              idl = 1'b1;
            end
          end
        end
      end
      m_out <= o; m_base <= b; m_pend <= p; m_drop <= d;
      m_idle <= idl; m_in_pulse <= pl; m_rem <= r;
    end
  end

  always @(negedge clk) begin
    check("data_out", {31'd0, data_out}, {31'd0, m_out});
    check("busy",     {31'd0, busy},     {31'd0, !m_idle});
    check("pending",  {31'd0, pending},  {31'd0, m_pend || (data_in != m_out)});
    check("req_drop", {31'd0, req_drop}, {31'd0, m_drop});
  end

  // Activity monitors used by the literal expectations.
  int edges = 0;
  int low_ticks = 0;
  int drops = 0;
  always @(data_out) edges = edges + 1;
  always @(posedge clk) if (tick_en && data_out == 1'b0) low_ticks <= low_ticks + 1;
  always @(posedge clk) if (req_drop) drops <= drops + 1;

  // Timebase: one tick every four cycles.
  initial begin
    int phase;
    phase   = 0;
    tick_en = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      tick_en = (phase == 3);
      phase   = (phase + 1) % 4;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse();
    pulse_req = 1'b1;
    step(1);
    pulse_req = 1'b0;
  endtask

  initial begin
    int e0, lt0, d0;
    rst_n = 1'b0; data_in = 1'b1; pulse_req = 1'b0;

    // Reset state.
    step(3);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_out", {31'd0, data_out}, 32'd1);
    check("rst_pending", {31'd0, pending}, 32'd0);
    data_in = 1'b0;
    #1 check("rst_pending_diff", {31'd0, pending}, 32'd1);
    data_in = 1'b1;
    rst_n = 1'b1;

    // Steady 1: the post-reset hold expires and the block goes idle.
    step(30);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_out", {31'd0, data_out}, 32'd1);

    // Level change, then a glitch inside the hold window is absorbed.
    e0 = edges;
    data_in = 1'b0;
    step(1);
    check("chg_latency", {31'd0, data_out}, 32'd0);
    step(8);
    data_in = 1'b1;
    step(8);
    data_in = 1'b0;
    step(30);
    check("glitch_edges", edges - e0, 32'd1);
    check("glitch_out", {31'd0, data_out}, 32'd0);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Single pulse on base 1.
    data_in = 1'b1;
    step(30);
    e0 = edges; lt0 = low_ticks;
    pulse();
    check("pulse_start", {31'd0, data_out}, 32'd0);
    step(60);
    check("pulse_width", low_ticks - lt0, H);
    check("pulse_edges", edges - e0, 32'd2);
    check("pulse_out", {31'd0, data_out}, 32'd1);
    check("pulse_busy", {31'd0, busy}, 32'd0);

    // Three requests during one pulse: one is queued and two are dropped.
    e0 = edges; d0 = drops;
    pulse();
    step(1);
    pulse();
    step(1);
    pulse();
    check("drop1", {31'd0, req_drop}, 32'd1);
    pulse();
    check("drop2", {31'd0, req_drop}, 32'd1);
    step(130);
    check("queue_drops", drops - d0, 32'd2);
    check("queue_edges", edges - e0, 32'd4);
    check("queue_busy", {31'd0, busy}, 32'd0);

    // A pulse and a level change in the same idle cycle: the pulse goes first.
    e0 = edges;
    data_in = 1'b0;
    pulse();
    check("both_pulse_first", {31'd0, data_out}, 32'd0);
    step(30);
    check("both_restore", {31'd0, data_out}, 32'd1);
    step(60);
    check("both_edges", edges - e0, 32'd3);
    check("both_out", {31'd0, data_out}, 32'd0);
    check("both_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a pulse that has a request queued.
    data_in = 1'b1;
    step(30);
    e0 = edges;
    pulse();
    step(12);
    pulse();
    check("mid_pulse_out", {31'd0, data_out}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", {31'd0, data_out}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd1);
    check("async_rst_pend", {31'd0, pending}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    step(40);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    check("post_rst_out", {31'd0, data_out}, 32'd1);
    check("post_rst_edges", edges - e0, 32'd2);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/level_hold_driver.md
# level_hold_driver

Output-side conditioner for slow board-level control signals (resets, enables, handshake strobes) driven from the CPLD. It drives `o_data_out` so that every level is held for at least `HOLD_TICKS` enable ticks. A receiving `lowpass_filter` running on the same tick therefore always captures each level. It also generates fixed-width inverted pulses on request, with a one-deep request queue.

## Interface
- `HOLD_TICKS`, default 6: minimum number of `i_tick_en` ticks each output level is held. Must be ≥1. The default covers a `lowpass_filter` with TOTAL_STAGES=5.
- `INIT_VALUE`, default 1: output level while in reset and after reset.
- `CNT_W`, default 8: hold counter width. Requires 2^CNT_W ≥ HOLD_TICKS.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_tick_en`  in  1  timebase strobe, one cycle wide. This is the same strobe the receiver uses as its filter enable.
- `i_data_in`  in  1  requested steady level.
- `i_pulse_req`  in  1  one-cycle request for an inverted pulse of `HOLD_TICKS` ticks.
- `o_data_out`  out  1  conditioned output, registered.
- `o_busy`  out  1  high when state ≠ IDLE.
- `o_pending`  out  1  high when a pulse request is queued, or when `i_data_in` ≠ `o_data_out`.
- `o_req_drop`  out  1  one-cycle strobe indicating a pulse request was discarded.

## Operation
- State machine states: IDLE, HOLD, PULSE.
- Internal registers: `r_base` (steady level), `r_cnt[CNT_W-1:0]`, `r_pend` (queued pulse).
- Reset values: `o_data_out`=INIT_VALUE, `r_base`=INIT_VALUE, state=HOLD, `r_cnt`=0, `r_pend`=0, `o_req_drop`=0. At reset, `o_busy`=1 and `o_pending`=(`i_data_in`≠INIT_VALUE).
- IDLE decisions, evaluated in priority order:
  - If `i_pulse_req` or `r_pend`: drive `o_data_out`←~`r_base`, clear `r_pend`, `r_cnt`←0, go to PULSE.
  - Else if `i_data_in`≠`r_base`: drive `o_data_out` and `r_base` ← `i_data_in`, `r_cnt`←0, go to HOLD.
  - Else: stay in IDLE.
- HOLD: on each `i_tick_en`, `r_cnt`←`r_cnt`+1. When `i_tick_en` is high and `r_cnt`==HOLD_TICKS-1, go to IDLE. `o_data_out` stays at `r_base`.
- PULSE: counts ticks exactly as HOLD does. On the terminal tick, drive `o_data_out`←`r_base`, `r_cnt`←0, go to HOLD. The restored base level is therefore also held for the minimum time.
- `i_data_in` is not latched outside IDLE. Its value is sampled only in IDLE, so the last value wins, and excursions that start and end inside a hold window are absorbed without effect.
- `i_pulse_req` received while not in IDLE:
  - If `r_pend`=0, set `r_pend`.
  - If `r_pend`=1, leave `r_pend` set and assert `o_req_drop` for one cycle.
- `i_pulse_req` received in IDLE is served immediately, and `r_pend` stays 0.
- A pulse request in the same cycle as a level change in IDLE: the pulse wins. The level change is taken after the pulse plus its restore hold.
- Asserting `i_rst_n` mid-pulse or mid-hold returns every register to its reset value asynchronously. A queued request is lost.
- `i_tick_en` stuck low freezes the state machine in HOLD or PULSE. This is legal; there is no timeout.

## Timing
- Latency: a level change sampled in IDLE at edge N appears on `o_data_out` after edge N. The same applies to a pulse start.
- Counting starts in the first cycle `o_data_out` shows the new level. A tick in the decision cycle is not counted.
- Minimum level duration: from the change edge until the HOLD_TICKS-th counted tick, plus 1 cycle for the IDLE decision.
- Pulse width: HOLD_TICKS counted ticks.
- Back-to-back pulses: each pulse is separated by at least HOLD_TICKS ticks at `r_base`, plus 1 cycle.
- All outputs are registered with no combinational path from inputs. The exception is `o_pending`, which compares `i_data_in` combinationally.

## Structure
- No shared package. State encoding and its 2-bit width are localparams in this block.
- One sub-module, `hold_tick_counter`:
  - Ports: clear, `i_tick_en`, terminal-count output `o_done`.
  - Parameters: `HOLD_TICKS`, `CNT_W`.
  - Shared by HOLD and PULSE.

## Test plan
- Reset, then `i_data_in`=1 constant with a tick every 4 cycles: `o_data_out`=1 throughout, `o_busy` falls after 6 ticks, `o_pending`=0.
- In IDLE, `i_data_in` 1→0: `o_data_out`=0 one cycle later. A 2-tick 0→1→0 glitch during the hold gives no change. Driving a lowpass_filter with TOTAL_STAGES=5 produces a single clean 1→0.
- `i_pulse_req` in IDLE with base 1: output is 0 for exactly 6 ticks, then 1 held for at least 6 ticks, then IDLE.
- Three `i_pulse_req` during one pulse: the first is queued (`o_pending`=1), the second and third each give a 1-cycle `o_req_drop`, and exactly two pulses are emitted in total.
- `i_pulse_req` and a level change in the same IDLE cycle: the pulse comes first, then after the restore hold `o_data_out` takes the new level.
- `i_rst_n` low at tick 3 of a pulse: `o_data_out`=INIT_VALUE immediately, `r_pend` is cleared, and after release the block is in HOLD with `o_busy`=1.
